// File: rtl/csr_regfile_if.sv
// Bus between SYSTEM_EXU (master) and the machine-mode CSR file (slave).
`timescale 1ns/1ps
interface csr_regfile_if;
    logic        valid;
    logic [11:0] csr_addr;
    logic [63:0] csr_data;
    logic        csr_is_w;
    logic [11:0] result_csr_addr;
    logic [63:0] result_csr_data;
    logic        is_except;
    logic [5:0]  exception;
    logic [63:0] pc;
    logic        retire;
    logic [63:0] mepc;
    logic [63:0] mstatus;
    logic        trap_valid_next_pc;
    logic [63:0] trap_next_pc;

    modport master (
        output valid, csr_addr, csr_is_w, result_csr_addr, result_csr_data,
               is_except, exception, pc, retire,
        input  csr_data, mepc, mstatus, trap_valid_next_pc, trap_next_pc
    );

    modport slave (
        input  valid, csr_addr, csr_is_w, result_csr_addr, result_csr_data,
               is_except, exception, pc, retire,
        output csr_data, mepc, mstatus, trap_valid_next_pc, trap_next_pc
    );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage and trap-entry sequencer for SYSTEM_EXU.
// Define CSR_COUNTERS_EN to implement the mcycle/minstret counters.
`timescale 1ns/1ps
module csr_regfile #(
    parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_8000_0000,
    parameter logic [63:0] HART_ID     = 64'd0
) (
    input  logic           clock,
    input  logic           reset,
    csr_regfile_if.slave   io
);
    localparam logic [63:0] MSTATUS_RESET = 64'h0000_000A_0000_1800;
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
    localparam logic [63:0] MISA_VALUE    = 64'h8000_0000_0000_1100;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    logic [63:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip;
    logic        wr_en;
    logic        unused;

    // A trap in the same cycle as a CSR write drops the write.
    assign wr_en  = io.csr_is_w && !io.is_except;
    assign unused = &{1'b0, io.valid, io.pc[1:0]};

    assign io.mepc               = mepc;
    assign io.mstatus            = mstatus;
    assign io.trap_valid_next_pc = io.is_except;
    assign io.trap_next_pc       = {mtvec[63:2], 2'b00};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mstatus  <= MSTATUS_RESET;
            mie      <= '0;
            mtvec    <= MTVEC_RESET;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mip      <= '0;
        end else if (io.is_except) begin
            mepc    <= {io.pc[63:2], 2'b00};
            mcause  <= {58'd0, io.exception};
            // MPP<=11, MPIE<=MIE, MIE<=0
            mstatus <= {mstatus[63:13], 2'b11, mstatus[10:8], mstatus[3],
                        mstatus[6:4], 1'b0, mstatus[2:0]};
        end else if (wr_en) begin
            case (io.result_csr_addr)
                A_MSTATUS:  mstatus  <= (mstatus & ~MSTATUS_WMASK) |
                                        (io.result_csr_data & MSTATUS_WMASK);
                A_MIE:      mie      <= io.result_csr_data;
                A_MTVEC:    mtvec    <= io.result_csr_data;
                A_MSCRATCH: mscratch <= io.result_csr_data;
                A_MEPC:     mepc     <= {io.result_csr_data[63:2], 2'b00};
                A_MCAUSE:   mcause   <= io.result_csr_data;
                A_MTVAL:    mtval    <= io.result_csr_data;
                A_MIP:      mip      <= io.result_csr_data;
                default:    ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_en && io.result_csr_addr == A_MCYCLE)
                mcycle <= io.result_csr_data;
            else
                mcycle <= mcycle + 64'd1;
            if (wr_en && io.result_csr_addr == A_MINSTRET)
                minstret <= io.result_csr_data;
            else if (io.retire)
                minstret <= minstret + 64'd1;
        end
    end
`endif

    // Reads see the current register contents; writes land at the next edge.
    always_comb begin
        io.csr_data = '0;
        case (io.csr_addr)
            A_MSTATUS:  io.csr_data = mstatus;
            A_MISA:     io.csr_data = MISA_VALUE;
            A_MIE:      io.csr_data = mie;
            A_MTVEC:    io.csr_data = mtvec;
            A_MSCRATCH: io.csr_data = mscratch;
            A_MEPC:     io.csr_data = mepc;
            A_MCAUSE:   io.csr_data = mcause;
            A_MTVAL:    io.csr_data = mtval;
            A_MIP:      io.csr_data = mip;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:   io.csr_data = mcycle;
            A_MINSTRET: io.csr_data = minstret;
`endif
            A_MHARTID:  io.csr_data = HART_ID;
            default:    io.csr_data = '0;
        endcase
    end
endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset values, write masks, trap entry, collisions, counters.
`timescale 1ns/1ps
module tb_csr_regfile;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    csr_regfile_if io_bus();

    csr_regfile #(
        .MTVEC_RESET(64'h0000_0000_8000_0000),
        .HART_ID    (64'd0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io   (io_bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, input string tag, input logic [63:0] exp);
        io_bus.csr_addr = addr;
        #1;
        check(tag, io_bus.csr_data, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [63:0] data);
        io_bus.csr_is_w        = 1'b1;
        io_bus.result_csr_addr = addr;
        io_bus.result_csr_data = data;
        tick();
        io_bus.csr_is_w        = 1'b0;
    endtask

    initial begin
        io_bus.valid           = 1'b0;
        io_bus.csr_addr        = 12'h000;
        io_bus.csr_is_w        = 1'b0;
        io_bus.result_csr_addr = 12'h000;
        io_bus.result_csr_data = 64'd0;
        io_bus.is_except       = 1'b0;
        io_bus.exception       = 6'd0;
        io_bus.pc              = 64'd0;
        io_bus.retire          = 1'b0;

        // Reset values while reset is held
        #12;
        check("rst_mstatus_out", io_bus.mstatus, 64'h0000_000A_0000_1800);
        check("rst_mepc_out", io_bus.mepc, 64'd0);
        check("rst_trap_valid", {63'd0, io_bus.trap_valid_next_pc}, 64'd0);
        check("rst_trap_pc", io_bus.trap_next_pc, 64'h8000_0000);
        rd(12'h300, "rst_mstatus", 64'h0000_000A_0000_1800);
        rd(12'h305, "rst_mtvec", 64'h8000_0000);
        rd(12'hF14, "rst_mhartid", 64'd0);
        rd(12'h301, "rst_misa", 64'h8000_0000_0000_1100);
        reset = 1'b1;
        io_bus.valid = 1'b1;
        tick();
        rd(12'h7C0, "unmapped_read", 64'd0);

        // mstatus mask; same-cycle read returns pre-write value
        io_bus.csr_is_w        = 1'b1;
        io_bus.result_csr_addr = 12'h300;
        io_bus.result_csr_data = '1;
        rd(12'h300, "mstatus_prewrite", 64'h0000_000A_0000_1800);
        tick();
        io_bus.csr_is_w = 1'b0;
        rd(12'h300, "mstatus_mask", 64'h0000_000A_0000_1888);

        wr(12'h341, 64'h1003);
        rd(12'h341, "mepc_align", 64'h1000);
        wr(12'h340, 64'hAA);
        rd(12'h340, "mscratch_rw", 64'hAA);

        // Read-only and unmapped writes are ignored
        wr(12'h301, 64'd0);
        rd(12'h301, "misa_ro", 64'h8000_0000_0000_1100);
        wr(12'hF14, 64'd5);
        rd(12'hF14, "mhartid_ro", 64'd0);
        wr(12'h7C0, 64'hFF);
        rd(12'h7C0, "unmapped_write", 64'd0);

        wr(12'h305, 64'h8000_0103);
        rd(12'h305, "mtvec_rw", 64'h8000_0103);
        check("trap_pc_align", io_bus.trap_next_pc, 64'h8000_0100);

        // MIE=1, MPIE=0, MPP=00 before the trap
        wr(12'h300, 64'h8);
        rd(12'h300, "mstatus_pretrap", 64'h0000_000A_0000_0008);

        // Trap colliding with a mscratch write
        io_bus.is_except       = 1'b1;
        io_bus.pc              = 64'h8000_0010;
        io_bus.exception       = 6'd11;
        io_bus.csr_is_w        = 1'b1;
        io_bus.result_csr_addr = 12'h340;
        io_bus.result_csr_data = 64'h55;
        #1;
        check("trap_valid_now", {63'd0, io_bus.trap_valid_next_pc}, 64'd1);
        check("trap_next_pc", io_bus.trap_next_pc, 64'h8000_0100);
        tick();
        io_bus.is_except = 1'b0;
        io_bus.csr_is_w  = 1'b0;
        #1;
        check("trap_valid_clr", {63'd0, io_bus.trap_valid_next_pc}, 64'd0);
        check("trap_mepc", io_bus.mepc, 64'h8000_0010);
        check("trap_mstatus", io_bus.mstatus, 64'h0000_000A_0000_1880);
        rd(12'h342, "trap_mcause", 64'd11);
        rd(12'h340, "trap_collision", 64'hAA);

        // Second trap: misaligned pc, MIE already 0
        io_bus.is_except = 1'b1;
        io_bus.pc        = 64'h8000_0027;
        io_bus.exception = 6'd3;
        tick();
        io_bus.is_except = 1'b0;
        check("trap2_mepc", io_bus.mepc, 64'h8000_0024);
        check("trap2_mstatus", io_bus.mstatus, 64'h0000_000A_0000_1800);
        rd(12'h342, "trap2_mcause", 64'd3);

        wr(12'h304, 64'hDEAD_BEEF_0123_4567);
        wr(12'h344, 64'h8000_0000_0000_0001);
        wr(12'h343, 64'hFFFF_0000_FFFF_0000);
        wr(12'h342, 64'h8000_0000_0000_0007);
        rd(12'h304, "mie_rw", 64'hDEAD_BEEF_0123_4567);
        rd(12'h344, "mip_rw", 64'h8000_0000_0000_0001);
        rd(12'h343, "mtval_rw", 64'hFFFF_0000_FFFF_0000);
        rd(12'h342, "mcause_rw", 64'h8000_0000_0000_0007);

`ifdef CSR_COUNTERS_EN
        wr(12'hB00, '1);
        rd(12'hB00, "mcycle_load", 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd(12'hB00, "mcycle_wrap", 64'd0);
        tick();
        rd(12'hB00, "mcycle_inc", 64'd1);

        io_bus.retire = 1'b1;
        wr(12'hB02, 64'd7);
        rd(12'hB02, "minstret_collide", 64'd7);
        tick();
        tick();
        io_bus.retire = 1'b0;
        rd(12'hB02, "minstret_retire", 64'd9);
        tick();
        rd(12'hB02, "minstret_hold", 64'd9);
        wr(12'hB02, '1);
        io_bus.retire = 1'b1;
        tick();
        io_bus.retire = 1'b0;
        rd(12'hB02, "minstret_wrap", 64'd0);
`else
        wr(12'hB00, '1);
        rd(12'hB00, "mcycle_absent", 64'd0);
        tick();
        rd(12'hB00, "mcycle_absent2", 64'd0);
        io_bus.retire = 1'b1;
        wr(12'hB02, 64'd7);
        io_bus.retire = 1'b0;
        rd(12'hB02, "minstret_absent", 64'd0);
`endif

        // Asynchronous reset mid-operation discards a pending write
        io_bus.csr_is_w        = 1'b1;
        io_bus.result_csr_addr = 12'h340;
        io_bus.result_csr_data = 64'h99;
        #1;
        reset = 1'b0;
        rd(12'h340, "async_rst_mscratch", 64'd0);
        check("async_rst_mstatus", io_bus.mstatus, 64'h0000_000A_0000_1800);
        check("async_rst_mepc", io_bus.mepc, 64'd0);
        tick();
        rd(12'h340, "rst_hold_mscratch", 64'd0);
        rd(12'h305, "rst_hold_mtvec", 64'h8000_0000);
        io_bus.csr_is_w = 1'b0;
        reset = 1'b1;
        tick();
        rd(12'h340, "post_rst_mscratch", 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
